// File: rtl/lifo_pop_stack_pkg.sv
// Shared defaults, state encoding and helpers for the LIFO pop stack.
package stack_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned ADDR_WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_PARTIAL = 2'd1,
    S_FULL    = 2'd2
  } stack_state_e;

  function automatic int unsigned depth_of(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

// File: rtl/lifo_pop_stack_if.sv
// Push/pop request bus and status of the LIFO pop stack.
interface lifo_pop_stack_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
);
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic [ADDR_WIDTH:0]   count;
  logic                  empty;
  logic                  full;
  logic                  overflow_flag;
  logic                  underflow_flag;

  modport master (
    output push, pop, data_in,
    input  data_out, data_valid, count, empty, full, overflow_flag, underflow_flag
  );

  modport slave (
    input  push, pop, data_in,
    output data_out, data_valid, count, empty, full, overflow_flag, underflow_flag
  );
endinterface

// File: rtl/lifo_pop_stack_counter.sv
// Up/down stack-pointer counter, saturating at 0 and 2**ADDR_WIDTH.
module stack_pointer_counter
  import stack_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                clear,
  input  logic                inc,
  input  logic                dec,
  output logic [ADDR_WIDTH:0] count,
  output logic                at_zero,
  output logic                at_max
);

  localparam logic [ADDR_WIDTH:0] MAX_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  assign at_zero = (count == '0);
  assign at_max  = (count == MAX_COUNT);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && !dec && !at_max) begin
      count <= count + 1'b1;
    end else if (dec && !inc && !at_zero) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/lifo_pop_stack.sv
// LIFO stack with registered pop data and overflow/underflow reporting.
// Build option: LIFO_STICKY_FLAGS_EN makes the fault flags hold until reset.
module lifo_pop_stack
  import stack_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic             control_clock,
  input  logic             reset,
  lifo_pop_stack_if.slave  bus
);

  localparam int unsigned         DEPTH      = depth_of(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] LAST_COUNT = (ADDR_WIDTH+1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] ONE_COUNT  = (ADDR_WIDTH+1)'(1);

  stack_state_e          state;
  stack_state_e          state_next;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   count;
  logic                  at_zero;
  logic                  at_max;
  logic                  do_inc;
  logic                  do_dec;
  logic                  do_swap;
  logic                  do_read;
  logic                  do_write;
  logic                  ovf_evt;
  logic                  unf_evt;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH-1:0] wr_addr;

  stack_pointer_counter #(.ADDR_WIDTH(ADDR_WIDTH)) u_sp (
    .clk     (control_clock),
    .clear   (reset),
    .inc     (do_inc),
    .dec     (do_dec),
    .count   (count),
    .at_zero (at_zero),
    .at_max  (at_max)
  );

  // Push+pop on a non-empty stack overwrites the top in place; on an empty
  // stack the push still lands and only the pop is rejected.
  always_comb begin
    do_swap  = bus.push && bus.pop && !at_zero;
    do_inc   = bus.push && !at_max && (!bus.pop || at_zero);
    do_dec   = bus.pop && !bus.push && !at_zero;
    do_read  = bus.pop && !at_zero;
    do_write = do_inc || do_swap;
    ovf_evt  = bus.push && !bus.pop && at_max;
    unf_evt  = bus.pop && at_zero;
    rd_addr  = count[ADDR_WIDTH-1:0] - 1'b1;
    wr_addr  = do_swap ? rd_addr : count[ADDR_WIDTH-1:0];
  end

  always_comb begin
    state_next = state;
    if (do_inc) begin
      state_next = (count == LAST_COUNT) ? S_FULL : S_PARTIAL;
    end else if (do_dec) begin
      state_next = (count == ONE_COUNT) ? S_EMPTY : S_PARTIAL;
    end
  end

  always_ff @(posedge control_clock) begin
    if (reset) begin
      state <= S_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge control_clock) begin
    if (do_write && !reset) begin
      mem[wr_addr] <= bus.data_in;
    end
  end

  always_ff @(posedge control_clock) begin
    if (reset) begin
      bus.data_out       <= '0;
      bus.data_valid     <= 1'b0;
      bus.overflow_flag  <= 1'b0;
      bus.underflow_flag <= 1'b0;
    end else begin
      bus.data_valid <= do_read;
      if (do_read) begin
        bus.data_out <= mem[rd_addr];
      end
`ifdef LIFO_STICKY_FLAGS_EN
      bus.overflow_flag  <= bus.overflow_flag  || ovf_evt;
      bus.underflow_flag <= bus.underflow_flag || unf_evt;
`else
      bus.overflow_flag  <= ovf_evt;
      bus.underflow_flag <= unf_evt;
`endif
    end
  end

  assign bus.count = count;
  assign bus.empty = (state == S_EMPTY);
  assign bus.full  = (state == S_FULL);

endmodule

// File: tb/tb_lifo_pop_stack.sv
// Bench for lifo_pop_stack (depth 4): directed vector table plus random traffic against a queue model.
module tb_lifo_pop_stack;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 2;
  localparam int unsigned DEPTH = 4;

  logic clk;
  logic rst;

  lifo_pop_stack_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  lifo_pop_stack #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_dut (
    .control_clock (clk),
    .reset         (rst),
    .bus           (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          push;
    logic          pop;
    logic [DW-1:0] din;
    logic [AW:0]   exp_count;
    logic [DW-1:0] exp_dout;
    logic          exp_valid;
    logic          exp_ovf;
    logic          exp_unf;
  } vec_t;

  vec_t tbl[$];

  int n_vec;
  int n_err;

  // Reference model: a queue whose back is the top of the stack.
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_dout;
  logic          m_valid;
  logic          m_ovf;
  logic          m_unf;

  task automatic add(input logic r, input logic p, input logic q, input logic [DW-1:0] d,
                     input logic [AW:0] c, input logic [DW-1:0] o, input logic v,
                     input logic fo, input logic fu);
    vec_t t;
    t.rst = r; t.push = p; t.pop = q; t.din = d;
    t.exp_count = c; t.exp_dout = o; t.exp_valid = v; t.exp_ovf = fo; t.exp_unf = fu;
    tbl.push_back(t);
  endtask

  task automatic model_step(input logic r, input logic p, input logic q, input logic [DW-1:0] d);
    logic ovf_p;
    logic unf_p;
    ovf_p = 1'b0;
    unf_p = 1'b0;
    if (r) begin
      m_q.delete();
      m_dout  = '0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
    end else begin
      m_valid = 1'b0;
      if (p && q) begin
        if (m_q.size() == 0) begin
          m_q.push_back(d);
          unf_p = 1'b1;
        end else begin
          m_dout  = m_q.pop_back();
          m_valid = 1'b1;
          m_q.push_back(d);
        end
      end else if (p) begin
        if (m_q.size() == DEPTH) ovf_p = 1'b1;
        else m_q.push_back(d);
      end else if (q) begin
        if (m_q.size() == 0) unf_p = 1'b1;
        else begin
          m_dout  = m_q.pop_back();
          m_valid = 1'b1;
        end
      end
`ifdef LIFO_STICKY_FLAGS_EN
      m_ovf = m_ovf | ovf_p;
      m_unf = m_unf | unf_p;
`else
      m_ovf = ovf_p;
      m_unf = unf_p;
`endif
    end
  endtask

  function automatic logic [15:0] pack(input logic [AW:0] c, input logic e, input logic f,
                                       input logic [DW-1:0] o, input logic v,
                                       input logic fo, input logic fu);
    return {c, e, f, o, v, fo, fu};
  endfunction

  task automatic compare(input string name, input logic [15:0] exp);
    logic [15:0] act;
    act = pack(bus.count, bus.empty, bus.full, bus.data_out, bus.data_valid,
               bus.overflow_flag, bus.underflow_flag);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t {count,empty,full,dout,valid,ovf,unf} actual=%h required=%h",
               name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic p, input logic q, input logic [DW-1:0] d);
    rst          = r;
    bus.push     = p;
    bus.pop      = q;
    bus.data_in  = d;
  endtask

  // One clock with model-predicted checking; called with the clock low.
  task automatic cycle(input logic r, input logic p, input logic q, input logic [DW-1:0] d,
                       input string name);
    logic [AW:0] c;
    drive(r, p, q, d);
    @(posedge clk);
    model_step(r, p, q, d);
    #1;
    c = (AW+1)'(m_q.size());
    compare(name, pack(c, c == 0, c == DEPTH, m_dout, m_valid, m_ovf, m_unf));
    @(negedge clk);
  endtask

  initial begin
    logic acc_ovf;
    logic acc_unf;
    logic fo;
    logic fu;
    logic [AW:0] c;
    string nm;

    n_vec = 0;
    n_err = 0;
    acc_ovf = 1'b0;
    acc_unf = 1'b0;
    drive(1'b1, 1'b0, 1'b0, '0);

    //   rst   push  pop   din    count  dout   valid ovf   unf
    add(1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 8'h11, 3'd1, 8'h00, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 8'h22, 3'd2, 8'h00, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 8'h33, 3'd3, 8'h00, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 8'h44, 3'd4, 8'h00, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 8'h55, 3'd4, 8'h00, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 8'h00, 3'd4, 8'h00, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 8'h00, 3'd3, 8'h44, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 8'h00, 3'd2, 8'h33, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 8'h00, 3'd1, 8'h22, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 8'h00, 3'd0, 8'h11, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 8'h00, 3'd0, 8'h11, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 8'h11, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 8'hA1, 3'd1, 8'h11, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 8'hA2, 3'd2, 8'h11, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 8'hB0, 3'd2, 8'hA2, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 8'h00, 3'd1, 8'hB0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 8'h00, 3'd0, 8'hA1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 8'h5A, 3'd1, 8'hA1, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 8'h00, 3'd0, 8'h5A, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 8'h01, 3'd1, 8'h5A, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 8'h02, 3'd2, 8'h5A, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b1, 8'h00, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].push, tbl[i].pop, tbl[i].din);
      @(posedge clk);
      model_step(tbl[i].rst, tbl[i].push, tbl[i].pop, tbl[i].din);
      #1;
      if (tbl[i].rst) begin
        acc_ovf = 1'b0;
        acc_unf = 1'b0;
      end else begin
        acc_ovf = acc_ovf | tbl[i].exp_ovf;
        acc_unf = acc_unf | tbl[i].exp_unf;
      end
`ifdef LIFO_STICKY_FLAGS_EN
      fo = acc_ovf;
      fu = acc_unf;
`else
      fo = tbl[i].exp_ovf;
      fu = tbl[i].exp_unf;
`endif
      c = tbl[i].exp_count;
      nm = $sformatf("tbl[%0d]", i);
      compare(nm, pack(c, c == 0, c == DEPTH, tbl[i].exp_dout, tbl[i].exp_valid, fo, fu));
      @(negedge clk);
    end

    // Underflow followed by idle cycles: pulse clears, or holds when sticky.
    cycle(1'b1, 1'b0, 1'b0, 8'h00, "unf_seq_reset");
    cycle(1'b0, 1'b0, 1'b1, 8'h00, "unf_seq_pop_empty");
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, "unf_seq_idle");
    cycle(1'b1, 1'b0, 1'b0, 8'h00, "unf_seq_clear");

    // Overflow pulse followed by a swap on a full stack.
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 8'(8'hC0 + i), "ovf_seq_push");
    cycle(1'b0, 1'b1, 1'b1, 8'hEE, "ovf_seq_swap_full");
    cycle(1'b0, 1'b0, 1'b1, 8'h00, "ovf_seq_pop_swapped");
    cycle(1'b0, 1'b0, 1'b0, 8'h00, "ovf_seq_idle");

    cycle(1'b1, 1'b0, 1'b0, 8'h00, "rand_reset");
    for (int i = 0; i < 600; i++) begin
      logic r;
      logic p;
      logic q;
      r = ($urandom_range(0, 59) == 0);
      p = ($urandom_range(0, 99) < 55);
      q = ($urandom_range(0, 99) < 50);
      cycle(r, p, q, 8'($urandom_range(0, 255)), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lifo_pop_stack.md
Name: lifo_pop_stack

Overview:
- Last-in-first-out storage block: the pop (read-back) end of the PUSH path.
- Push writes a word at the stack pointer; pop returns the most recently pushed word.
- Internally uses a bidirectional stack-pointer counter with overflow/underflow reporting, the up/down counterpart of the existing push-only counter.
- Sits between the RAM/ROM datapath and control logic that sequences push/pop requests.

Parameters:
DATA_WIDTH, 8, width of each stored word
ADDR_WIDTH, 4, pointer width; depth = 2**ADDR_WIDTH entries

Ports:
control_clock  input  1  single clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
push  input  1  request: store data_in on top of stack this cycle
pop  input  1  request: remove top word and return it
data_in  input  DATA_WIDTH  word to push
data_out  output  DATA_WIDTH  registered popped word
data_valid  output  1  one-cycle pulse: data_out holds a newly popped word
count  output  ADDR_WIDTH+1  number of stored words, 0..2**ADDR_WIDTH
empty  output  1  count == 0
full  output  1  count == 2**ADDR_WIDTH
overflow_flag  output  1  push rejected because stack full
underflow_flag  output  1  pop rejected because stack empty

Behaviour:
- Reset (sync, active-high, sampled on control_clock edge):
  - count=0, data_out=0, data_valid=0, overflow_flag=0, underflow_flag=0, empty=1, full=0, state=S_EMPTY.
  - Memory contents are not cleared.
  - Reset wins over push/pop in the same cycle.
- States: S_EMPTY (count=0), S_PARTIAL (0<count<depth), S_FULL (count=depth). empty/full decode the state combinationally from the registered state.
- Push only, not full:
  - mem[count] <= data_in; count+1.
  - Transitions: S_EMPTY->S_PARTIAL; S_PARTIAL->S_FULL when count reaches depth (with depth 1, S_EMPTY->S_FULL directly).
- Pop only, not empty:
  - data_out <= mem[count-1]; data_valid=1 next cycle; count-1.
  - Transitions: S_FULL->S_PARTIAL; S_PARTIAL->S_EMPTY when count reaches 0.
- Latency: pop request at edge N gives data_out/data_valid visible after edge N+1, i.e. one cycle.
- Push+pop same cycle, not empty (S_PARTIAL or S_FULL):
  - data_out <= old top mem[count-1]; mem[count-1] <= data_in.
  - count unchanged; data_valid=1; no flags.
- Push+pop same cycle, empty: push performed, pop rejected; underflow_flag=1, data_valid=0, count=1.
- Push when full (no pop): write ignored, count unchanged, overflow_flag=1 for one cycle.
- Pop when empty (no push): no change, data_out holds last value, data_valid=0, underflow_flag=1 for one cycle.
- Flags are single-cycle pulses registered on the offending edge; absence of a fault clears them next cycle.
- data_out holds its value between pops; data_valid is 0 on every cycle without a successful pop.
- count never wraps: arithmetic is ADDR_WIDTH+1 bits, saturating at the 0 and depth boundaries by rule.
- Reset mid-operation: a pending pop result is discarded; data_valid=0 the cycle after reset.

Optional Feature:
- Macro: LIFO_STICKY_FLAGS_EN.
- Defined: overflow_flag and underflow_flag are sticky; once set they stay 1 until reset.
- Undefined: one-cycle pulses as above.
- Stack data behaviour is identical in both builds.

Decomposition:
- Package stack_pkg: DATA_WIDTH/ADDR_WIDTH defaults, state encoding S_EMPTY=2'd0, S_PARTIAL=2'd1, S_FULL=2'd2.
- Sub-module stack_pointer_counter: up/down saturating counter with inc, dec, and count outputs, plus at_zero and at_max decode. It owns the count register; the top level owns memory, data_out, flags and state.

Test Plan (ADDR_WIDTH=2, depth 4, DATA_WIDTH=8):
- Reset then idle 3 cycles -> count=0, empty=1, full=0, data_valid=0, all flags 0.
- Push 0x11,0x22,0x33,0x44 -> count=4, full=1; a 5th push of 0x55 -> overflow_flag=1 for one cycle, count stays 4.
- From full, pop x4 -> data_out 0x44,0x33,0x22,0x11 each one cycle after its pop with data_valid=1; then empty=1. A 5th pop -> underflow_flag=1, data_valid=0, data_out stays 0x11.
- Push 0xA1,0xA2, then push 0xB0 with pop in the same cycle -> data_out=0xA2, count stays 2; a next pop returns 0xB0.
- Empty stack, push 0x5A with pop in the same cycle -> underflow_flag=1, count=1; a following pop returns 0x5A.
- Push x2 then assert reset together with pop -> count=0, data_valid=0 next cycle. With LIFO_STICKY_FLAGS_EN: after an underflow, the flag stays 1 across 10 cycles until reset.
